pixel_link_rx: RTL and testbench

// - Receiver for the two-wire LED-array link (d_clk, d_out) driven by the pixel writer.
// - Detects frame start/stop, deserialises bytes LSB-first and flags framing errors.
// - Sits on the bench/loopback side of the PMod LED-array link, or on a slave FPGA emulating the array.
// - Presents one byte per valid pulse to downstream logic.

---
 rtl/pixel_link_pkg.sv | 28 ++
 rtl/pixel_link_rx_sync.sv | 41 ++++
 rtl/pixel_link_rx.sv | 157 +++++++++++++++
 tb/tb_pixel_link_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_link_pkg.sv
// ============================================================================
// Module : pixel_link_pkg
// Brief  : Shared state, line-level and rate definitions for the PMod LED-array
//          pixel link (writer and receiver).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pixel_link_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } link_state_t;

   localparam logic LINK_IDLE_LEVEL   = 1'b1;

   localparam int   CLK_IN_RATE_HZ    = 12_000_000;
   localparam int   CLK_PIXEL_RATE_HZ = 1_000_000;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int count_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : pixel_link_pkg

`default_nettype wire

// File: rtl/pixel_link_rx_sync.sv
// ============================================================================
// Module : link_line_sync
// Brief  : Multi-flop synchroniser plus one history flop for a link pin; all
//          flops reset to the idle line level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module link_line_sync
   import pixel_link_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic s,
   output logic p
);

   localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [c_STAGES-1:0] r_sync;
   logic                r_hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {c_STAGES{LINK_IDLE_LEVEL}};
         r_hist <= LINK_IDLE_LEVEL;
      end else begin
         r_sync <= {r_sync[c_STAGES-2:0], pin};
         r_hist <= r_sync[c_STAGES-1];
      end
   end

   assign s = r_sync[c_STAGES-1];
   assign p = r_hist;

endmodule : link_line_sync

`default_nettype wire

// File: rtl/pixel_link_rx.sv
// ============================================================================
// Module : pixel_link_rx
// Brief  : Two-wire LED-array link receiver: start/stop detection, LSB-first
//          byte deserialisation, inactivity timeout and framing-error flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_link_rx
   import pixel_link_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_clk,
   input  logic       d_in,
   output logic [7:0] value,
   output logic       valid,
   output logic       first,
   output logic       busy,
   output logic       frame_err,
   output logic [7:0] byte_count
);

   localparam int                 c_TMO_W    = count_width(TIMEOUT_CYCLES);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

   logic w_s_clk, w_p_clk, w_s_dat, w_p_dat;
   logic w_clk_rise, w_start, w_stop, w_line_edge;

   link_state_t        r_state;
   logic [7:0]         r_shift;
   logic [2:0]         r_bit_cnt;
   logic               r_first_pend;
   logic [c_TMO_W-1:0] r_tmo;
   logic               r_byte_done;
   logic [7:0]         r_value;
   logic               r_valid;
   logic               r_first;
   logic               r_frame_err;
   logic [7:0]         r_byte_count;

   link_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk   (clk),
      .reset (reset),
      .pin   (d_clk),
      .s     (w_s_clk),
      .p     (w_p_clk)
   );

   link_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
      .clk   (clk),
      .reset (reset),
      .pin   (d_in),
      .s     (w_s_dat),
      .p     (w_p_dat)
   );

   // Start/stop need the clock high in both samples, so a data change that
   // lands together with a clock change is never a frame delimiter.
   assign w_clk_rise  = w_s_clk & ~w_p_clk;
   assign w_start     = w_p_clk & w_s_clk &  w_p_dat & ~w_s_dat;
   assign w_stop      = w_p_clk & w_s_clk & ~w_p_dat &  w_s_dat;
   assign w_line_edge = (w_s_clk ^ w_p_clk) | (w_s_dat ^ w_p_dat);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_first_pend <= 1'b0;
         r_tmo        <= '0;
         r_byte_done  <= 1'b0;
         r_value      <= 8'h00;
         r_valid      <= 1'b0;
         r_first      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_byte_count <= 8'h00;
      end else begin
         r_valid     <= 1'b0;
         r_first     <= 1'b0;
         r_frame_err <= 1'b0;
         r_byte_done <= 1'b0;

         // Byte publication runs one cycle behind the final shift.
         if (r_byte_done) begin
            r_value      <= r_shift;
            r_valid      <= 1'b1;
            r_first      <= r_first_pend;
            r_first_pend <= 1'b0;
            if (r_byte_count != 8'hFF) begin
               r_byte_count <= r_byte_count + 8'd1;
            end
         end

         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state      <= RECV;
                  r_bit_cnt    <= 3'd0;
                  r_byte_count <= 8'h00;
                  r_first_pend <= 1'b1;
                  r_tmo        <= '0;
               end
            end

            RECV: begin
               if (w_start) begin
                  r_bit_cnt    <= 3'd0;
                  r_byte_count <= 8'h00;
                  r_first_pend <= 1'b1;
                  r_tmo        <= '0;
                  r_frame_err  <= (r_bit_cnt != 3'd0);
               end else if (w_stop) begin
                  r_state     <= IDLE;
                  r_tmo       <= '0;
                  r_frame_err <= (r_bit_cnt != 3'd0);
               end else if (!w_line_edge && (r_tmo == c_TMO_LAST)) begin
                  r_state     <= IDLE;
                  r_tmo       <= '0;
                  r_frame_err <= 1'b1;
               end else begin
                  if (w_line_edge) begin
                     r_tmo <= '0;
                  end else begin
                     r_tmo <= r_tmo + c_TMO_ONE;
                  end
                  if (w_clk_rise) begin
                     r_shift   <= {w_s_dat, r_shift[7:1]};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign value      = r_value;
   assign valid      = r_valid;
   assign first      = r_first;
   assign busy       = (r_state == RECV);
   assign frame_err  = r_frame_err;
   assign byte_count = r_byte_count;

endmodule : pixel_link_rx

`default_nettype wire

// File: tb/tb_pixel_link_rx.sv
// ============================================================================
// Module : tb_pixel_link_rx
// Brief  : Self-checking bench for pixel_link_rx: table of frames plus
//          hand-written error, timeout, reset and restart sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_link_rx;

   localparam int c_HALF = 6;   // 12 MHz clk, 1 MHz link clock

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       d_clk = 1'b1;
   logic       d_in = 1'b1;
   logic [7:0] value;
   logic       valid;
   logic       first;
   logic       busy;
   logic       frame_err;
   logic [7:0] byte_count;

   typedef struct {
      logic [7:0] value;
      logic       first;
      logic [7:0] bc;
   } exp_t;

   typedef struct {
      int         n;
      logic [7:0] b [3];
      logic [7:0] exp_value;
   } frame_vec_t;

   exp_t       sb_q [$];
   exp_t       mon_e;
   frame_vec_t tv [4];
   int         n_checks = 0;
   int         n_pass = 0;
   int         err_cnt = 0;
   int         exp_err = 0;
   logic       prev_valid = 1'b0;
   logic       prev_err = 1'b0;

   always #5 clk = ~clk;

   pixel_link_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1200)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_clk      (d_clk),
      .d_in       (d_in),
      .value      (value),
      .valid      (valid),
      .first      (first),
      .busy       (busy),
      .frame_err  (frame_err),
      .byte_count (byte_count)
   );

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) err_cnt++;
         if (frame_err && prev_err) check("frame_err_one_cycle", 1, 0);
         if (valid && prev_valid) check("valid_one_cycle", 1, 0);
         if (valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", int'(value), -1);
            end else begin
               mon_e = sb_q.pop_front();
               check("value", int'(value), int'(mon_e.value));
               check("first", int'(first), int'(mon_e.first));
               check("byte_count", int'(byte_count), int'(mon_e.bc));
            end
         end
      end
      prev_valid = valid;
      prev_err   = frame_err;
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start();
      d_clk = 1'b1; d_in = 1'b1; hold(c_HALF);
      d_in = 1'b0; hold(c_HALF);
   endtask

   // Data changes together with the falling clock edge, exercising the
   // simultaneous-change case on every bit.
   task automatic send_bit(input logic b);
      d_clk = 1'b0; d_in = b; hold(c_HALF);
      d_clk = 1'b1; hold(c_HALF);
   endtask

   task automatic send_byte(input logic [7:0] v, input logic f, input logic [7:0] bc);
      exp_t e;
      e.value = v; e.first = f; e.bc = bc;
      sb_q.push_back(e);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   // With the clock high a falling data line is a (repeated) start, so a
   // high last bit needs a drop before the rising stop.
   task automatic send_stop();
      if (d_in) begin
         d_in = 1'b0; hold(c_HALF);
      end
      d_in = 1'b1; hold(c_HALF);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      check(name, sb_q.size(), 0);
   endtask

   task automatic send_frame(input frame_vec_t f);
      send_start();
      check("busy_in_frame", int'(busy), 1);
      for (int i = 0; i < f.n; i++) send_byte(f.b[i], (i == 0), 8'(i + 1));
      send_stop();
      hold(4);
   endtask

   initial begin
      tv[0] = '{n: 1, b: '{8'hA5, 8'h00, 8'h00}, exp_value: 8'hA5};
      tv[1] = '{n: 3, b: '{8'h40, 8'h12, 8'hFF}, exp_value: 8'hFF};
      tv[2] = '{n: 1, b: '{8'h3C, 8'h00, 8'h00}, exp_value: 8'h3C};
      tv[3] = '{n: 2, b: '{8'h00, 8'h7E, 8'h00}, exp_value: 8'h7E};

      hold(5);
      reset = 1'b0;
      hold(3);
      check("rst_value", int'(value), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_first", int'(first), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_byte_count", int'(byte_count), 0);

      for (int k = 0; k < 4; k++) begin
         send_frame(tv[k]);
         wait_drain("tbl_drained");
         check("tbl_busy_after_stop", int'(busy), 0);
         check("tbl_value_held", int'(value), int'(tv[k].exp_value));
         check("tbl_frame_err_count", err_cnt, exp_err);
      end

      // Short frame: three bits then stop.
      send_start();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_stop();
      exp_err++;
      hold(4);
      check("short_err", err_cnt, exp_err);
      check("short_busy", int'(busy), 0);
      check("short_value_kept", int'(value), 8'h7E);

      // Inactivity timeout after five bits.
      send_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      exp_err++;
      for (int i = 0; i < 1500 && err_cnt < exp_err; i++) @(negedge clk);
      check("tmo_err", err_cnt, exp_err);
      check("tmo_idle", int'(busy), 0);
      d_in = 1'b1; hold(c_HALF);
      send_frame(tv[2]);
      wait_drain("tmo_next_drained");
      check("tmo_next_value", int'(value), 8'h3C);
      check("tmo_next_err", err_cnt, exp_err);

      // Repeated start while a partial byte is pending.
      send_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      d_in = 1'b0; hold(c_HALF);
      exp_err++;
      check("rstart_err", err_cnt, exp_err);
      check("rstart_busy", int'(busy), 1);
      send_byte(8'h66, 1'b1, 8'd1);
      send_stop();
      hold(4);
      wait_drain("rstart_drained");
      check("rstart_value", int'(value), 8'h66);

      // Reset in the middle of 0x81.
      send_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      reset = 1'b1; d_clk = 1'b1; d_in = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_value", int'(value), 0);
      check("mid_rst_valid", int'(valid), 0);
      check("mid_rst_first", int'(first), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_frame_err", int'(frame_err), 0);
      check("mid_rst_byte_count", int'(byte_count), 0);
      hold(3);
      reset = 1'b0;
      hold(20);
      check("post_rst_no_start", int'(busy), 0);
      check("post_rst_no_err", err_cnt, exp_err);

      // Byte 0x01, end and reopen the frame, then 0x02 and stop.
      send_start();
      send_byte(8'h01, 1'b1, 8'd1);
      d_in = 1'b1; hold(c_HALF);
      d_in = 1'b0; hold(c_HALF);
      send_byte(8'h02, 1'b1, 8'd1);
      send_stop();
      hold(4);
      wait_drain("restart_drained");
      check("restart_byte_count", int'(byte_count), 1);
      check("restart_busy", int'(busy), 0);
      check("restart_err", err_cnt, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: run did not complete, checks %0d", n_checks);
      $fatal(1);
   end

endmodule : tb_pixel_link_rx

`default_nettype wire
